// File: rtl/cic_comp_fir.sv
// Decimate-by-2 compensation FIR behind the CIC decimator: one shared multiplier,
// one MAC per clk over all taps, rounded and saturated output with a valid pulse.
module cic_comp_fir #(
  parameter int IN_W   = 31,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_W-1:0]     d_in,
  input  logic                       d_clk,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic signed [OUT_W-1:0]    d_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = IN_W + COEF_W + AW;

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1'b1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       d_clk_q;
  logic [AW-1:0]              wptr_q;
  logic                       phase_q;
  logic [AW-1:0]              k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0]    d_out_q;
  logic                       out_valid_q;
  logic                       overrun_q;
  logic signed [IN_W-1:0]     buf_q  [TAPS];
  logic signed [COEF_W-1:0]   coef_q [TAPS];

  logic                       strobe_s;
  logic                       accept_s;
  logic [AW-1:0]              rd_idx_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    rnd_s;
  logic signed [ACC_W-1:0]    shf_s;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI[OUT_W-1:0];
    end else if (v < SAT_LO) begin
      r = SAT_LO[OUT_W-1:0];
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

  assign strobe_s = d_clk & ~d_clk_q;
  assign accept_s = strobe_s & (state_q == S_IDLE);
  // Newest sample sits just behind the write pointer; tap k looks k further back.
  assign rd_idx_s = wptr_q - AW'(1'b1) - k_q;
  assign prod_s   = PROD_W'(buf_q[rd_idx_s]) * PROD_W'(coef_q[k_q]);
  assign rnd_s    = acc_q + RND;
  assign shf_s    = rnd_s >>> SHIFT;

  // Next-state and MAC datapath
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && phase_q) begin
          state_d = S_MAC;
          k_d     = {AW{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        k_d   = k_q + AW'(1'b1);
        if (k_q == AW'(TAPS - 1)) begin
          state_d = S_OUT;
        end else begin
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, sample buffer, coefficient store and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      d_clk_q     <= 1'b0;
      wptr_q      <= {AW{1'b0}};
      phase_q     <= 1'b0;
      k_q         <= {AW{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      d_out_q     <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i]  <= {IN_W{1'b0}};
        coef_q[i] <= {COEF_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      d_clk_q     <= d_clk;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= (state_q == S_OUT);
      if (accept_s) begin
        buf_q[wptr_q] <= d_in;
        wptr_q        <= wptr_q + AW'(1'b1);
        phase_q       <= ~phase_q;
      end
      if (strobe_s && !accept_s) begin
        overrun_q <= 1'b1;
      end
      if (coef_we && (state_q == S_IDLE)) begin
        coef_q[coef_addr] <= coef_data;
      end
      if (state_q == S_OUT) begin
        d_out_q <= sat_out(shf_s);
      end
    end
  end

  assign d_out     = d_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed/randomised bench for cic_comp_fir; expected outputs come from a
// sample-history FIR model with explicit output timing.
module tb_cic_comp_fir;

  localparam int TAPS  = 16;
  localparam int OUT_W = 24;
  localparam int SHIFT = 22;
  localparam int LAT   = TAPS + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [30:0] d_in;
  logic               d_clk;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [23:0] d_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  cic_comp_fir dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .d_clk     (d_clk),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .d_out     (d_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     c;
    longint v;
  } ev_t;

  int     cyc = 0;
  ev_t    got_q[$];
  ev_t    exp_q[$];
  longint hist[$];
  longint coef_m[TAPS];
  int     n_acc;
  bit     ovr_m;
  int     mac_t;
  int     n_cmp = 0;
  int     n_err = 0;

  // Cycle index: value during a cycle equals the number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the cycle it appeared in
  always @(negedge clk) begin
    ev_t e;
    if (out_valid === 1'b1) begin
      e.c = cyc;
      e.v = longint'(d_out);
      got_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy_at(input int t);
    return (t >= mac_t + 1) && (t <= mac_t + TAPS + 1);
  endfunction

  // Direct-form FIR over the accepted-sample history, then round and saturate.
  function automatic longint model_out();
    longint acc = 64'sd0;
    longint r;
    longint hi = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    longint lo = -(64'sd1 <<< (OUT_W - 1));
    for (int k = 0; k < TAPS; k++) begin
      acc += coef_m[k] * hist[hist.size() - 1 - k];
    end
    r = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 64'sd0;
    hist.delete();
    for (int i = 0; i < TAPS; i++) hist.push_back(64'sd0);
    n_acc = 0;
    ovr_m = 1'b0;
    mac_t = -1000;
  endfunction

  task automatic feed(input logic signed [30:0] x, input bit we, input int k, input int v, input int gap);
    int t;
    bit b;
    ev_t e;
    t = cyc;
    b = busy_at(t);
    d_in      = x;
    d_clk     = 1'b1;
    coef_we   = we;
    coef_addr = 4'(k);
    coef_data = 16'(v);
    if (we && !b) coef_m[k] = longint'(v);
    if (b) begin
      ovr_m = 1'b1;
    end else begin
      hist.push_back(longint'(x));
      n_acc++;
      if ((n_acc % 2) == 0) begin
        mac_t = t;
        e.c = t + LAT;
        e.v = model_out();
        exp_q.push_back(e);
      end
    end
    tick();
    d_clk   = 1'b0;
    coef_we = 1'b0;
    chk("busy_after_strobe", busy, busy_at(t + 1));
    chk("overrun_flag", overrun, ovr_m);
    repeat (gap - 1) tick();
  endtask

  task automatic wcoef(input int k, input int v);
    if (!busy_at(cyc)) coef_m[k] = longint'(v);
    coef_we   = 1'b1;
    coef_addr = 4'(k);
    coef_data = 16'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_reset(input int n);
    int r;
    r = cyc;
    rst = 1'b1;
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].c > r) void'(exp_q.pop_back());
    model_reset();
    tick();
    chk("busy_in_reset", busy, 1'b0);
    repeat (n - 1) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_dout", d_out, 0);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cycle"}, got_q[i].c, exp_q[i].c);
      chk({tag, "_value"}, got_q[i].v, exp_q[i].v);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic signed [30:0] xs;
    logic signed [15:0] cs;
    rst       = 1'b1;
    d_in      = '0;
    d_clk     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();

    // Reset, then zero coefficients: outputs only on even samples, all zero
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      xs = 31'($urandom());
      feed(xs, 1'b0, 0, 0, 20);
    end
    check_outputs("zero_coef");

    // Unity-ish gain and latency
    wcoef(0, 16384);
    feed(31'sd8388608, 1'b0, 0, 0, 20);
    feed(31'sd8388608, 1'b0, 0, 0, 20);
    check_outputs("gain");
    chk("gain_dout", d_out, 32768);

    // Impulse response on a clean buffer
    do_reset(2);
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    feed(31'sd4194304, 1'b0, 0, 0, 40);
    for (int i = 0; i < 19; i++) feed(31'sd0, 1'b0, 0, 0, 40);
    chk("impulse_pulses", got_q.size(), 10);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("impulse_tap", got_q[i].v, (i < 8) ? 2 * (i + 1) : 0);
    end
    check_outputs("impulse");

    // Saturation at both rails
    for (int k = 0; k < TAPS; k++) wcoef(k, 32767);
    for (int i = 0; i < 16; i++) feed(31'sd1073741823, 1'b0, 0, 0, 20);
    chk("sat_hi", d_out, 8388607);
    for (int i = 0; i < 16; i++) feed(-31'sd1073741824, 1'b0, 0, 0, 20);
    chk("sat_lo", d_out, -8388608);
    check_outputs("saturation");

    // Random coefficients and samples, with some coefficient writes on the strobe cycle
    for (int k = 0; k < TAPS; k++) begin
      cs = 16'($urandom());
      wcoef(k, int'(cs));
    end
    for (int i = 0; i < 12; i++) begin
      xs = 31'($urandom());
      cs = 16'($urandom());
      feed(xs, 1'($urandom_range(1, 0)), int'($urandom_range(TAPS - 1, 0)), int'(cs), TAPS + 3);
    end
    check_outputs("random");

    // Coefficient write while busy is ignored
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 20);
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 3);
    cs = 16'($urandom());
    wcoef(0, int'(cs));
    repeat (20) tick();
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 20);
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 20);
    check_outputs("busy_write");

    // Two strobes dropped during a MAC pass
    for (int i = 0; i < 6; i++) begin
      xs = 31'($urandom());
      feed(xs, 1'b0, 0, 0, (i == 1) ? 3 : ((i == 2) ? 5 : 20));
    end
    check_outputs("overrun");
    chk("overrun_sticky", overrun, 1'b1);

    // Reset in the middle of a pass: no output, coefficients cleared
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 20);
    xs = 31'($urandom());
    feed(xs, 1'b0, 0, 0, 5);
    do_reset(1);
    repeat (30) tick();
    check_outputs("reset_mid_mac");
    feed(31'sd4194304, 1'b0, 0, 0, 20);
    for (int i = 0; i < 3; i++) feed(31'sd0, 1'b0, 0, 0, 20);
    check_outputs("post_reset_impulse");
    chk("post_reset_dout", d_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
